// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and frame-length helper for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_WIDTH   = 8;

    // Total clk cycles of one frame, measured from the start-bit falling edge.
    function automatic int frame_cycles(input int width, input int parity,
                                        input int stop, input int cpb);
        return (1 + width + parity + stop) * cpb;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - free-running bit-period counter with clear and end-of-bit pulse
// Ports: clk, rst (sync, active high), clear (restart the bit period at 0),
//        bit_end (high during the last cycle of each CLKS_PER_BIT-cycle bit period).
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmitter draining a show-ahead FIFO, LSB first, optional even parity
// Ports: clk, rst (sync, active high), enable (permit new frames),
//        fifo_empty / fifo_rd_data (FIFO head, show-ahead), fifo_rd_en (combinational pop),
//        tx (registered serial line, idles high), busy (frame on line),
//        frame_done (one-cycle pulse after the last stop-bit cycle).
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    // One counter serves both data-bit and stop-bit counting.
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    uart_tx_state_e        state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic bit_end;
    logic stop_last;
    logic pop;

    // Counter is held at zero while idle so the start bit gets a full period.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (pop || (state_q == IDLE)),
        .bit_end(bit_end)
    );

    assign stop_last = (state_q == STOP) && bit_end && (bit_cnt_q == STOP_LAST);

    // Reset gates the pop so a word is never lost from the FIFO while in reset.
    assign pop = !rst && enable && !fifo_empty && ((state_q == IDLE) || stop_last);

    assign fifo_rd_en = pop;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        frame_done_d = stop_last;

        if (pop) begin
            state_d   = START;
            shift_d   = fifo_rd_data;
            bit_cnt_d = '0;
            parity_d  = 1'b0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state_d = DATA;
                        tx_d    = shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        parity_d = parity_q ^ shift_q[0];
                        shift_d  = shift_q >> 1;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            if (PARITY_EN != 0) begin
                                state_d = PARITY;
                                tx_d    = parity_q ^ shift_q[0];
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            tx_d      = shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            state_d   = IDLE;
                            bit_cnt_d = '0;
                            busy_d    = 1'b0;
                            tx_d      = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed-vector bench for fifo_uart_tx (no-parity and even-parity instances)
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic en0, en1;

    logic [7:0] mem0 [0:15];
    logic [7:0] mem1 [0:15];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    logic       empty0, empty1;
    logic [7:0] data0, data1;
    logic       rd_en0, rd_en1;
    logic       tx0, tx1, busy0, busy1, fd0, fd1;

    int n_vec = 0;
    int n_err = 0;
    int bad_pop = 0;
    int sel = 0;

    logic mon_tx, mon_busy, mon_fd, mon_rd;

    always #5 clk = ~clk;

    assign empty0 = (wr0 == rd0);
    assign empty1 = (wr1 == rd1);
    assign data0  = mem0[rd0[3:0]];
    assign data1  = mem1[rd1[3:0]];

    always @(posedge clk) begin
        if (rd_en0) rd0 <= rd0 + 1;
        if (rd_en1) rd1 <= rd1 + 1;
    end

    always @(negedge clk) begin
        if (rd_en0 && empty0) bad_pop++;
        if (rd_en1 && empty1) bad_pop++;
    end

    assign mon_tx   = (sel == 1) ? tx1    : tx0;
    assign mon_busy = (sel == 1) ? busy1  : busy0;
    assign mon_fd   = (sel == 1) ? fd1    : fd0;
    assign mon_rd   = (sel == 1) ? rd_en1 : rd_en0;

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .fifo_empty(empty0),
        .fifo_rd_data(data0), .fifo_rd_en(rd_en0), .tx(tx0),
        .busy(busy0), .frame_done(fd0)
    );

    fifo_uart_tx #(
        .DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)
    ) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .fifo_empty(empty1),
        .fifo_rd_data(data1), .fifo_rd_en(rd_en1), .tx(tx1),
        .busy(busy1), .frame_done(fd1)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wr0[3:0]] = d;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1[3:0]] = d;
        wr1 = wr1 + 1;
    endtask

    // Frame bits (bit 0 = start bit) stretched to CPB cycles each.
    function automatic logic [127:0] expand(input logic [31:0] bits, input int nb);
        logic [127:0] e;
        e = '0;
        for (int k = 0; k < nb * CPB; k++) e[k] = bits[k / CPB];
        return e;
    endfunction

    function automatic logic [127:0] ones(input int n);
        return (128'd1 << n) - 128'd1;
    endfunction

    // Waits for the start-bit falling edge, then records n cycles; index 0 is the first start-bit cycle.
    task automatic run_frame(input int n, input int drop_en_at,
                             output logic [127:0] c_tx, output logic [127:0] c_busy,
                             output logic [127:0] c_fd, output logic [127:0] c_rd);
        int t;
        c_tx = '0; c_busy = '0; c_fd = '0; c_rd = '0;
        t = 0;
        @(negedge clk);
        while (mon_tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", {127'd0, mon_tx}, 128'd0);
        if (mon_tx !== 1'b0) return;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            c_tx[k]   = mon_tx;
            c_busy[k] = mon_busy;
            c_fd[k]   = mon_fd;
            c_rd[k]   = mon_rd;
            if (k == drop_en_at) en0 = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] c_tx, c_busy, c_fd, c_rd;
        int idle_tx, idle_rd, idle_busy;

        rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx0",   {127'd0, tx0},    128'd1);
        check("rst_busy0", {127'd0, busy0},  128'd0);
        check("rst_fd0",   {127'd0, fd0},    128'd0);
        check("rst_rden0", {127'd0, rd_en0}, 128'd0);
        check("rst_tx1",   {127'd0, tx1},    128'd1);

        rst = 1'b0; en0 = 1'b1; en1 = 1'b1;
        idle_tx = 0; idle_rd = 0; idle_busy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) idle_tx++;
            if (rd_en0 !== 1'b0 || rd_en1 !== 1'b0) idle_rd++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0) idle_busy++;
        end
        check("idle_tx",   idle_tx,   0);
        check("idle_rden", idle_rd,   0);
        check("idle_busy", idle_busy, 0);

        // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle
        sel = 0;
        push0(8'hA5);
        run_frame(41, -1, c_tx, c_busy, c_fd, c_rd);
        check("a5_tx",   c_tx,   expand(32'b1_1101001010, 11) & ones(41));
        check("a5_busy", c_busy, ones(40));
        check("a5_fd",   c_fd,   128'd1 << 40);
        check("a5_rd",   c_rd,   128'd0);
        check("a5_fifo", wr0 - rd0, 0);

        // Even parity: 0xA5 -> parity 0, 0x07 -> parity 1, 44-cycle frames
        sel = 1;
        push1(8'hA5);
        run_frame(45, -1, c_tx, c_busy, c_fd, c_rd);
        check("pa5_tx",   c_tx,   expand(32'b1_10101001010, 12) & ones(45));
        check("pa5_busy", c_busy, ones(44));
        check("pa5_fd",   c_fd,   128'd1 << 44);
        push1(8'h07);
        run_frame(45, -1, c_tx, c_busy, c_fd, c_rd);
        check("p07_tx",   c_tx,   expand(32'b1_11000001110, 12) & ones(45));
        check("p07_fd",   c_fd,   128'd1 << 44);

        // Back-to-back 0x00, 0xFF: second pop in last stop cycle, no gap
        sel = 0;
        push0(8'h00);
        push0(8'hFF);
        run_frame(81, -1, c_tx, c_busy, c_fd, c_rd);
        check("b2b_tx",   c_tx,   expand(32'b1_1111111110_1000000000, 21) & ones(81));
        check("b2b_busy", c_busy, ones(80));
        check("b2b_fd",   c_fd,   (128'd1 << 40) | (128'd1 << 80));
        check("b2b_rd",   c_rd,   128'd1 << 39);
        check("b2b_fifo", wr0 - rd0, 0);

        // enable drops mid-frame of 0x3C with two words queued
        push0(8'h3C);
        push0(8'h11);
        push0(8'h22);
        run_frame(60, 10, c_tx, c_busy, c_fd, c_rd);
        check("en_tx",   c_tx,   expand(32'b11111_1001111000, 15) & ones(60));
        check("en_busy", c_busy, ones(40));
        check("en_fd",   c_fd,   128'd1 << 40);
        check("en_rd",   c_rd,   128'd0);
        check("en_fifo", wr0 - rd0, 2);

        // Reset 15 cycles into the 0x11 frame
        en0 = 1'b1;
        run_frame(15, -1, c_tx, c_busy, c_fd, c_rd);
        check("r11_tx", c_tx, expand(32'b0010, 4) & ones(15));
        rst = 1'b1;
        @(negedge clk);
        check("rmid_tx",   {127'd0, tx0},    128'd1);
        check("rmid_busy", {127'd0, busy0},  128'd0);
        check("rmid_fd",   {127'd0, fd0},    128'd0);
        check("rmid_rden", {127'd0, rd_en0}, 128'd0);
        @(negedge clk);
        check("rhold_rden", {127'd0, rd_en0}, 128'd0);
        check("rhold_fifo", wr0 - rd0, 1);
        rst = 1'b0;
        run_frame(41, -1, c_tx, c_busy, c_fd, c_rd);
        check("r22_tx",   c_tx,   expand(32'b1_1001000100, 11) & ones(41));
        check("r22_busy", c_busy, ones(40));
        check("r22_fd",   c_fd,   128'd1 << 40);
        check("r22_fifo", wr0 - rd0, 0);

        check("pop_when_empty", bad_pop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
